// File: rtl/imm_extend_pipe.sv
// Immediate extender behind a 2-entry skid buffer (main + skid), FIFO order, 1-cycle latency.
// Mode 11 (upper) is enabled by defining IMM_EXTEND_UPPER_EN; otherwise mode 11 yields 0 with out_err=1.
module imm_extend_pipe #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_imm,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_err
);

   localparam int EXT_W = OUT_W - IN_W;

   // Handshake: an item moves on a side when valid && ready at a rising edge; valid never
   // waits on ready, and out_data/out_err hold while out_valid && !out_ready.

   logic [OUT_W-1:0] sext;
   logic [OUT_W-1:0] ext_data;
   logic             ext_err;

   always_comb begin
      sext     = {{EXT_W{in_imm[IN_W-1]}}, in_imm};
      ext_data = '0;
      ext_err  = 1'b0;
      case (in_mode)
         2'b00: ext_data = {{EXT_W{1'b0}}, in_imm};
         2'b01: ext_data = sext;
         2'b10: ext_data = {sext[OUT_W-3:0], 2'b00};
         2'b11: begin
`ifdef IMM_EXTEND_UPPER_EN
            ext_data = {in_imm, {EXT_W{1'b0}}};
`else
            ext_err  = 1'b1;
`endif
         end
      endcase
   end

   logic             main_valid;
   logic [OUT_W-1:0] main_data;
   logic             main_err;
   logic             skid_empty;
   logic [OUT_W-1:0] skid_data;
   logic             skid_err;
   logic             accept;

   assign accept    = in_valid && skid_empty;
   assign in_ready  = skid_empty;
   assign out_valid = main_valid;
   assign out_data  = main_data;
   assign out_err   = main_err;

   // Main refills whenever it is empty or being drained; skid only fills while main is stuck.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         main_valid <= 1'b0;
         main_data  <= '0;
         main_err   <= 1'b0;
         skid_empty <= 1'b1;
         skid_data  <= '0;
         skid_err   <= 1'b0;
      end else if (!main_valid || out_ready) begin
         if (!skid_empty) begin
            main_valid <= 1'b1;
            main_data  <= skid_data;
            main_err   <= skid_err;
            skid_empty <= 1'b1;
         end else if (accept) begin
            main_valid <= 1'b1;
            main_data  <= ext_data;
            main_err   <= ext_err;
         end else begin
            main_valid <= 1'b0;
         end
      end else if (accept) begin
         skid_empty <= 1'b0;
         skid_data  <= ext_data;
         skid_err   <= ext_err;
      end
   end

endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 SHALL have parameter IN_W, default 16, immediate input width.
REQ-002 SHALL have parameter OUT_W, default 32, extended output width; OUT_W >= IN_W+2 is required.
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1, upstream offers an immediate.
REQ-006 SHALL have port in_ready, output, 1, block accepts the offer this cycle.
REQ-007 SHALL have port in_imm, input, IN_W, raw immediate field.
REQ-008 SHALL have port in_mode, input, 2, extension mode: 00 zero, 01 sign, 10 sign-shift-2 (branch), 11 upper.
REQ-009 SHALL have port out_valid, output, 1, out_data holds a result.
REQ-010 SHALL have port out_ready, input, 1, downstream consumes this cycle.
REQ-011 SHALL have port out_data, output, OUT_W, extended result.
REQ-012 SHALL have port out_err, output, 1, result came from an unsupported mode; qualified by out_valid.

Function
REQ-013 Mode 00 SHALL produce {(OUT_W-IN_W) zeros, in_imm}.
REQ-014 Mode 01 SHALL replicate in_imm[IN_W-1] into the upper OUT_W-IN_W bits.
REQ-015 Mode 10 SHALL sign-extend, then shift left 2 and fill the vacated bits with zeros, truncated to OUT_W.
REQ-016 Mode 11 SHALL be as defined in Configuration.
REQ-017 Accept SHALL occur when in_valid && in_ready; transfer SHALL occur when out_valid && out_ready.
REQ-018 Storage SHALL be a 2-entry skid buffer (main + skid register), FIFO order preserved.
REQ-019 Latency SHALL be 1 cycle: an item accepted at edge N appears on out_data after edge N if main is empty.
REQ-020 Throughput SHALL be 1 item/cycle while out_ready stays high.
REQ-021 in_ready SHALL be a register output equal to "skid entry empty"; it SHALL NOT depend combinationally on out_ready.
REQ-022 With main full and out_ready low, an accept SHALL load the skid entry, and in_ready SHALL drop on the next cycle.
REQ-023 Simultaneous accept and transfer SHALL both proceed. Skid contents move to main, or the new item enters main if skid is empty, and occupancy is unchanged.
REQ-024 With both entries full, in_ready SHALL be 0, and in_valid SHALL be ignored.
REQ-025 out_data and out_err SHALL remain stable while out_valid && !out_ready.
REQ-026 in_mode and in_imm SHALL be sampled only on accept.

Reset
REQ-027 While rst_n=0 at a rising edge, both entries SHALL empty and any in-flight items SHALL be discarded.
REQ-028 Reset values SHALL be out_valid=0, out_data=0, out_err=0, in_ready=1, taking effect on the first edge with rst_n=0.
REQ-029 An accept presented in the same cycle as reset SHALL be discarded.

Configuration
REQ-030 Macro IMM_EXTEND_UPPER_EN SHALL control mode 11.
REQ-031 With IMM_EXTEND_UPPER_EN defined, mode 11 SHALL produce in_imm << (OUT_W-IN_W) with a zero low part, and out_err=0.
REQ-032 Without IMM_EXTEND_UPPER_EN, mode 11 SHALL produce out_data=0 and out_err=1, with handshake and ordering unchanged.
REQ-033 Modes 00, 01 and 10 SHALL always produce out_err=0.

Verification (defaults IN_W=16, OUT_W=32)
REQ-034 Mode 01 with imm 0x8000 -> 0xFFFF8000; mode 01 with 0x7FFF -> 0x00007FFF, out_valid 1 cycle after accept.
REQ-035 Mode 00 with imm 0x8000 -> 0x00008000; mode 10 with 0xFFFF -> 0xFFFFFFFC; mode 10 with 0x0001 -> 0x00000004.
REQ-036 Mode 11 with imm 0x1234 -> 0x12340000 and out_err=0 with the macro defined; out_data=0x00000000 and out_err=1 without it.
REQ-037 Back-pressure: out_ready=0, offer A, B, C back-to-back -> A and B accepted, in_ready=0 while C is held; raise out_ready -> A, B, C delivered in order with no loss or duplication.
REQ-038 Continuous streaming: 100 random items with out_ready toggling randomly -> output sequence equals the reference-model sequence, and out_data is stable during every stall.
REQ-039 Reset mid-operation: both entries full, assert rst_n=0 for 1 cycle -> out_valid=0, in_ready=1 next cycle, and no stale item is emitted afterwards.
